// File: rtl/alu_pkg.sv
// Shared definitions for the ALU writeback stage.
//   - NZCV bit positions inside a 4-bit flag vector.
//   - alu_result_t: one buffered ALU result, {d, nzcv}.
//   - make_nzcv(): flag derivation from a raw ALU result.
package alu_pkg;

    localparam int ALU_W = 32;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    typedef struct packed {
        logic [ALU_W-1:0] d;
        logic [3:0]       nzcv;
    } alu_result_t;

    function automatic logic [3:0] make_nzcv(input logic [ALU_W-1:0] d,
                                             input logic cout,
                                             input logic v);
        logic [3:0] f;
        f         = 4'b0000;
        f[FLAG_N] = d[ALU_W-1];
        f[FLAG_Z] = (d == '0);
        f[FLAG_C] = cout;
        f[FLAG_V] = v;
        return f;
    endfunction

endpackage

// File: rtl/alu_result_stage_fifo.sv
// result_fifo: DEPTH-entry synchronous FIFO of entry_t.
// Ports:
//   clk, rst_n    clock, synchronous active-low reset (empties the FIFO)
//   push, push_data  write request; ignored when full (even if a pop happens)
//   pop           read request; ignored when empty
//   head          oldest entry, all-zero when empty
//   full, empty   derived from the registered occupancy only
//   count         occupancy, 0..DEPTH
module result_fifo
    import alu_pkg::*;
#(
    parameter int  DEPTH   = 2,
    parameter type entry_t = alu_result_t
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  entry_t                     push_data,
    input  logic                       pop,
    output entry_t                     head,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_B = $clog2(DEPTH+1);

    entry_t             mem_q [DEPTH];
    entry_t             mem_d [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_B-1:0]   count_q, count_d;
    logic               do_push, do_pop;

    assign full  = (count_q == CNT_B'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;
    assign head  = empty ? '0 : mem_q[rd_ptr_q];

    // Push is gated by the registered full flag only, so a same-cycle pop
    // never opens a slot and there is no path from pop to push acceptance.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);  // DEPTH is a power of two: wraps naturally
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_B'(1);
            2'b01:   count_d = count_q - CNT_B'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/alu_result_stage.sv
// alu_result_stage: registered writeback stage behind the 32-bit ALU.
// Handshake: a transfer happens on a rising edge where valid && ready are both
// high; ready never depends combinationally on the partner's valid.
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   in_valid/in_ready     producer side; in_ready = !full (registered state)
//   in_d, in_cout, in_v   ALU result, carry-out, overflow
//   in_flag_we            on accept, also load flags with the result's NZCV
//   out_valid/out_ready   consumer side; out_valid = FIFO not empty
//   out_d, out_nzcv       FIFO head, zero when empty
//   flags                 architectural NZCV register
//   ovf_cnt, ovf_clr      saturating count of accepted results with V=1, and its clear
// WIDTH must equal alu_pkg::ALU_W since the buffered entry type is fixed there.
module alu_result_stage
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_W,
    parameter int DEPTH = 2,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_d,
    input  logic             in_cout,
    input  logic             in_v,
    input  logic             in_flag_we,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_d,
    output logic [3:0]       out_nzcv,
    output logic [3:0]       flags,
    output logic [CNT_W-1:0] ovf_cnt,
    input  logic             ovf_clr
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    alu_result_t                  in_entry;
    alu_result_t                  head;
    logic                         fifo_full, fifo_empty;
    logic [$clog2(DEPTH+1)-1:0]   fifo_count;
    logic                         accept;
    logic                         ovf_inc;

    logic [3:0]       flags_q, flags_d;
    logic [CNT_W-1:0] ovf_cnt_q, ovf_cnt_d;

    assign in_entry.d    = in_d;
    assign in_entry.nzcv = make_nzcv(in_d, in_cout, in_v);

    result_fifo #(
        .DEPTH   (DEPTH),
        .entry_t (alu_result_t)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (in_valid),
        .push_data (in_entry),
        .pop       (out_ready),
        .head      (head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign in_ready  = !fifo_full;
    assign out_valid = !fifo_empty;
    assign out_d     = head.d;
    assign out_nzcv  = head.nzcv;
    assign flags     = flags_q;
    assign ovf_cnt   = ovf_cnt_q;

    assign accept  = in_valid && !fifo_full;
    assign ovf_inc = accept && in_v;

    always_comb begin
        flags_d   = flags_q;
        ovf_cnt_d = ovf_cnt_q;
        if (accept && in_flag_we) begin
            flags_d = in_entry.nzcv;
        end
        // A clear coinciding with a counted event keeps that event.
        if (ovf_clr) begin
            ovf_cnt_d = ovf_inc ? CNT_W'(1) : '0;
        end else if (ovf_inc && (ovf_cnt_q != CNT_MAX)) begin
            ovf_cnt_d = ovf_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            flags_q   <= '0;
            ovf_cnt_q <= '0;
        end else begin
            flags_q   <= flags_d;
            ovf_cnt_q <= ovf_cnt_d;
        end
    end

endmodule

// File: tb/tb_alu_result_stage.sv
module tb_alu_result_stage;

  localparam int W     = 32;
  localparam int DEPTH = 2;
  localparam int NVEC  = 40;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          in_valid = 1'b0;
  logic [W-1:0]  in_d = '0;
  logic          in_cout = 1'b0;
  logic          in_v = 1'b0;
  logic          in_flag_we = 1'b0;
  logic          out_ready = 1'b0;
  logic          ovf_clr = 1'b0;

  logic          in_ready, out_valid;
  logic [W-1:0]  out_d;
  logic [3:0]    out_nzcv, flags;
  logic [7:0]    ovf_cnt;

  logic          in_ready2, out_valid2;
  logic [W-1:0]  out_d2;
  logic [3:0]    out_nzcv2, flags2;
  logic [1:0]    ovf_cnt2;

  alu_result_stage #(.WIDTH(W), .DEPTH(DEPTH), .CNT_W(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_d(in_d), .in_cout(in_cout), .in_v(in_v), .in_flag_we(in_flag_we),
    .out_valid(out_valid), .out_ready(out_ready), .out_d(out_d), .out_nzcv(out_nzcv),
    .flags(flags), .ovf_cnt(ovf_cnt), .ovf_clr(ovf_clr)
  );

  // Second instance with a 2-bit counter to reach saturation quickly.
  alu_result_stage #(.WIDTH(W), .DEPTH(DEPTH), .CNT_W(2)) u_dut_c2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready2),
    .in_d(in_d), .in_cout(in_cout), .in_v(in_v), .in_flag_we(in_flag_we),
    .out_valid(out_valid2), .out_ready(out_ready), .out_d(out_d2), .out_nzcv(out_nzcv2),
    .flags(flags2), .ovf_cnt(ovf_cnt2), .ovf_clr(ovf_clr)
  );

  // scoreboard / reference model
  logic [W+3:0] exp_q[$];
  logic [3:0]   m_flags;
  int           m_ovf;
  int           m_ovf2;
  int           n_checks = 0;
  int           n_errors = 0;
  int           n_pops = 0;

  typedef struct {
    logic         v;
    logic [W-1:0] d;
    logic         co;
    logic         ov;
    logic         fwe;
    logic         ordy;
    logic         clr;
  } vec_t;
  vec_t vecs[NVEC];

  function automatic logic [3:0] ref_nzcv(input logic [W-1:0] d, input logic co, input logic ov);
    return {d[W-1], (d == 0), co, ov};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_flags = 4'b0000;
    m_ovf   = 0;
    m_ovf2  = 0;
  endtask

  // Applies one cycle: drive inputs, check outputs against the model,
  // advance the model, clock, settle.
  task automatic cycle(input logic v, input logic [W-1:0] d, input logic co, input logic ov,
                       input logic fwe, input logic ordy, input logic clr);
    logic         acc, pop;
    logic [W+3:0] head;
    in_valid   = v;
    in_d       = d;
    in_cout    = co;
    in_v       = ov;
    in_flag_we = fwe;
    out_ready  = ordy;
    ovf_clr    = clr;
    #1;
    chk("out_valid", out_valid, exp_q.size() != 0);
    chk("in_ready", in_ready, exp_q.size() < DEPTH);
    chk("flags", flags, m_flags);
    chk("ovf_cnt", ovf_cnt, m_ovf);
    chk("ovf_cnt_c2", ovf_cnt2, m_ovf2);
    if (exp_q.size() != 0) head = exp_q[0];
    else head = '0;
    chk("out_d", out_d, head[W+3:4]);
    chk("out_nzcv", out_nzcv, head[3:0]);
    acc = v && (exp_q.size() < DEPTH);
    pop = ordy && (exp_q.size() != 0);
    if (pop) begin
      void'(exp_q.pop_front());
      n_pops++;
    end
    if (acc) begin
      exp_q.push_back({d, ref_nzcv(d, co, ov)});
      if (fwe) m_flags = ref_nzcv(d, co, ov);
    end
    if (clr) begin
      m_ovf  = (acc && ov) ? 1 : 0;
      m_ovf2 = (acc && ov) ? 1 : 0;
    end else if (acc && ov) begin
      if (m_ovf < 255) m_ovf++;
      if (m_ovf2 < 3) m_ovf2++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic ordy);
    cycle(1'b0, '0, 1'b0, 1'b0, 1'b0, ordy, 1'b0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    in_valid = 1'b0; out_ready = 1'b0; ovf_clr = 1'b0; in_flag_we = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    model_reset();
    for (int i = 0; i < NVEC; i++) begin
      vecs[i].v    = ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 3))
        0:       vecs[i].d = 32'h0000_0000;
        1:       vecs[i].d = 32'h8000_0000 | $urandom;
        default: vecs[i].d = $urandom;
      endcase
      vecs[i].co   = 1'($urandom_range(0, 1));
      vecs[i].ov   = 1'($urandom_range(0, 1));
      vecs[i].fwe  = 1'($urandom_range(0, 1));
      vecs[i].ordy = ($urandom_range(0, 2) != 0);
      vecs[i].clr  = ($urandom_range(0, 9) == 0);
    end

    // reset state
    do_reset();
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_out_d", out_d, 0);
    chk("rst_out_nzcv", out_nzcv, 4'b0000);
    chk("rst_flags", flags, 4'b0000);
    chk("rst_ovf_cnt", ovf_cnt, 0);

    // 1: single push of zero with carry, visible next cycle
    cycle(1'b1, 32'h0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("t1_out_valid", out_valid, 1'b1);
    chk("t1_out_nzcv", out_nzcv, 4'b0110);
    chk("t1_flags", flags, 4'b0110);

    // 2: stall fill, third push refused
    do_reset();
    cycle(1'b1, 32'h8000_0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 32'h0000_0001, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("t2_in_ready_full", in_ready, 1'b0);
    cycle(1'b1, 32'h0000_1234, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("t2_out_d", out_d, 32'h8000_0000);
    chk("t2_out_nzcv", out_nzcv, 4'b1000);
    // a pop while full must not let the waiting push in
    cycle(1'b1, 32'h0000_5678, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("t2_out_d_after_pop", out_d, 32'h0000_0001);
    chk("t2_in_ready_after_pop", in_ready, 1'b1);

    // 3: streaming at count=1, pointers wrap several times
    do_reset();
    n_pops = 0;
    cycle(1'b1, 32'h1111_0001, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 2; i <= 6; i++) cycle(1'b1, 32'h1111_0000 + i, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    idle(1'b1);
    idle(1'b1);
    chk("t3_pops", n_pops, 6);
    chk("t3_empty", out_valid, 1'b0);

    // 4: flag_we=0 leaves flags, overflow counted
    do_reset();
    cycle(1'b1, 32'h0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    cycle(1'b1, 32'hFFFF_FFFF, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    chk("t4_flags", flags, 4'b0110);
    chk("t4_out_nzcv", out_nzcv, 4'b1001);
    chk("t4_ovf_cnt", ovf_cnt, 1);

    // 5: saturation and clear
    do_reset();
    for (int i = 0; i < 5; i++) cycle(1'b1, 32'h7FFF_FFFF, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    chk("t5_sat_c2", ovf_cnt2, 2'd3);
    chk("t5_cnt8", ovf_cnt, 5);
    cycle(1'b1, 32'h7FFF_FFFF, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
    chk("t5_clr_inc_c2", ovf_cnt2, 2'd1);
    chk("t5_clr_inc", ovf_cnt, 1);
    cycle(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
    chk("t5_clr_only", ovf_cnt, 0);

    // 6: reset with entries buffered
    do_reset();
    cycle(1'b1, 32'h0000_00AA, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    cycle(1'b1, 32'h0000_00BB, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    do_reset();
    chk("t6_out_valid", out_valid, 1'b0);
    chk("t6_in_ready", in_ready, 1'b1);
    chk("t6_flags", flags, 4'b0000);
    chk("t6_ovf_cnt", ovf_cnt, 0);
    chk("t6_out_d", out_d, 0);

    // mixed traffic from the vector table
    for (int i = 0; i < NVEC; i++)
      cycle(vecs[i].v, vecs[i].d, vecs[i].co, vecs[i].ov, vecs[i].fwe, vecs[i].ordy, vecs[i].clr);
    for (int i = 0; i < DEPTH + 1; i++) idle(1'b1);
    chk("final_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
